tdm_rr_scheduler: RTL and testbench

- Round-robin, work-conserving time-slot scheduler for a 4-way TDM output channel.
- Four requesters raise req. The block grants one at a time for at most SLOT_LEN cycles and muxes the granted requester's data onto a registered output.
- Idle slots are skipped, so the shared 2-bit channel never carries a slot for a requester with nothing to send.

---
 rtl/tdm_rr_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_tdm_rr_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tdm_rr_scheduler
//
// Work-conserving round-robin time-slot scheduler for a 4-way TDM channel.
// One requester is granted at a time, for at most SLOT_LEN consecutive cycles.
// The granted requester's data is muxed onto a registered output. Slots for
// requesters with nothing to send are skipped.
//
// Parameters:
//   DATA_W    width of each requester data input and of out
//   SLOT_LEN  maximum consecutive cycles one grant may be held (1..16)
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous reset, active-low
//   req[3:0]   per-requester request, sampled at rising edges
//   in0..in3   requester data
//   grant      registered one-hot grant, all-zero when idle
//   slot_id    registered index of the current/last granted requester
//   out        registered channel data, holds its value while out_valid=0
//   out_valid  registered, 1 when out carries a transferred sample
// -----------------------------------------------------------------------------
module tdm_rr_scheduler #(
   parameter int unsigned DATA_W   = 2,
   parameter int unsigned SLOT_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   output logic [3:0]        grant,
   output logic [1:0]        slot_id,
   output logic [DATA_W-1:0] out,
   output logic              out_valid
);

   typedef enum logic [0:0] {
      StIdle,
      StBusy
   } state_e;

   // Final cycle index of a slot; count runs 0..LastCnt.
   localparam logic [3:0] LastCnt = 4'(SLOT_LEN - 1);

   state_e            state_q, state_d;
   logic [3:0]        grant_q, grant_d;
   logic [1:0]        slot_q,  slot_d;
   logic [1:0]        ptr_q,   ptr_d;
   logic [3:0]        count_q, count_d;
   logic [DATA_W-1:0] out_q,   out_d;
   logic              valid_q, valid_d;

   logic [1:0]        winner;
   logic [DATA_W-1:0] sel_data;
   logic              cur_req;
   logic              release_slot;

   // Round-robin pick: first set bit of r searching upward from last+1,
   // wrapping modulo 4. The 2-bit index sum wraps naturally.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [1:0] idx;
      logic       found;
      rr_pick = last;
      found   = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // In BUSY the pointer always equals slot_q, so one search serves both the
   // initial grant from IDLE and re-arbitration at a slot release.
   assign winner = rr_pick(req, ptr_q);

   always_comb begin
      sel_data = in0;
      case (slot_q)
         2'd0:    sel_data = in0;
         2'd1:    sel_data = in1;
         2'd2:    sel_data = in2;
         default: sel_data = in3;
      endcase
   end

   assign cur_req      = req[slot_q];
   assign release_slot = !cur_req || (count_q == LastCnt);

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      slot_d  = slot_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      out_d   = out_q;
      valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               grant_d = 4'b0001 << winner;
               slot_d  = winner;
               ptr_d   = winner;
               count_d = 4'd0;
               state_d = StBusy;
            end
         end

         StBusy: begin
            // Output lags grant by one cycle; a sample only moves when the
            // owner is still requesting, otherwise out keeps its last value.
            valid_d = cur_req;
            if (cur_req) begin
               out_d = sel_data;
            end

            if (release_slot) begin
               count_d = 4'd0;
               if (|req) begin
                  // Back-to-back handover, no idle gap; may re-grant slot_q.
                  grant_d = 4'b0001 << winner;
                  slot_d  = winner;
                  ptr_d   = winner;
               end else begin
                  grant_d = 4'b0000;
                  state_d = StIdle;
               end
            end else begin
               count_d = count_q + 4'd1;
            end
         end

         default: begin
            state_d = StIdle;
            grant_d = 4'b0000;
            count_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         grant_q <= 4'b0000;
         slot_q  <= 2'd0;
         ptr_q   <= 2'd3;  // requester 0 has first priority after reset
         count_q <= 4'd0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         slot_q  <= slot_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign grant     = grant_q;
   assign slot_id   = slot_q;
   assign out       = out_q;
   assign out_valid = valid_q;

`ifndef SYNTHESIS
   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst)
      $onehot0(grant_q));
   a_idle_no_grant : assert property (@(posedge clk) disable iff (!rst)
      (state_q == StIdle) |-> (grant_q == 4'b0000));
   a_busy_grant    : assert property (@(posedge clk) disable iff (!rst)
      (state_q == StBusy) |-> (grant_q == (4'b0001 << slot_q)));
   a_count_bound   : assert property (@(posedge clk) disable iff (!rst)
      count_q <= LastCnt);
`endif

endmodule

// File: tb/tb_tdm_rr_scheduler.sv
// Bench for tdm_rr_scheduler: a directed vector table, hand-written corner
// sequences, then randomized traffic against a slot-level reference model.
// Two instances run side by side: SLOT_LEN=4 and SLOT_LEN=1.
module tb_tdm_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [1:0] in0 = 2'd0;
   logic [1:0] in1 = 2'd0;
   logic [1:0] in2 = 2'd0;
   logic [1:0] in3 = 2'd0;

   logic [3:0] g4, g1;
   logic [1:0] s4, s1;
   logic [1:0] o4, o1;
   logic       v4, v1;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   tdm_rr_scheduler #(.DATA_W(2), .SLOT_LEN(4)) u_dut4 (
      .clk(clk), .rst(rst), .req(req),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .grant(g4), .slot_id(s4), .out(o4), .out_valid(v4)
   );

   tdm_rr_scheduler #(.DATA_W(2), .SLOT_LEN(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .grant(g1), .slot_id(s1), .out(o1), .out_valid(v1)
   );

   // ---------------- reference model (index 0: SLOT_LEN=4, 1: SLOT_LEN=1) ----
   int         m_slen [2] = '{4, 1};
   bit         m_busy [2];
   int         m_slot [2];
   int         m_last [2];
   int         m_held [2];   // cycles the current owner has held its grant
   logic [1:0] m_out  [2];
   bit         m_valid[2];

   function automatic int pick(input logic [3:0] r, input int last);
      for (int d = 1; d <= 4; d++) begin
         if (r[(last + d) % 4]) return (last + d) % 4;
      end
      return last;
   endfunction

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         m_busy[m]  = 0;
         m_slot[m]  = 0;
         m_last[m]  = 3;
         m_held[m]  = 0;
         m_out[m]   = 2'd0;
         m_valid[m] = 0;
      end
   endfunction

   function automatic void model_step();
      logic [1:0] din[4];
      int         k;
      int         w;
      din[0] = in0; din[1] = in1; din[2] = in2; din[3] = in3;
      for (int m = 0; m < 2; m++) begin
         if (!m_busy[m]) begin
            m_valid[m] = 0;
            if (req != 4'b0000) begin
               w         = pick(req, m_last[m]);
               m_busy[m] = 1;
               m_slot[m] = w;
               m_last[m] = w;
               m_held[m] = 1;
            end
         end else begin
            k          = m_slot[m];
            m_valid[m] = req[k];
            if (req[k]) m_out[m] = din[k];
            if (!req[k] || m_held[m] == m_slen[m]) begin
               if (req != 4'b0000) begin
                  w         = pick(req, k);
                  m_slot[m] = w;
                  m_last[m] = w;
                  m_held[m] = 1;
               end else begin
                  m_busy[m] = 0;
               end
            end else begin
               m_held[m] = m_held[m] + 1;
            end
         end
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name,
                        input logic [3:0] ag, input logic [1:0] as_, input logic [1:0] ao,
                        input logic av,
                        input logic [3:0] eg, input logic [1:0] es, input logic [1:0] eo,
                        input logic ev);
      n_total++;
      if ({ag, as_, ao, av} === {eg, es, eo, ev}) begin
         n_pass++;
      end else begin
         $display("FAIL %s @%0t: got grant=%b slot=%0d out=%0d valid=%b, want grant=%b slot=%0d out=%0d valid=%b",
                  name, $time, ag, as_, ao, av, eg, es, eo, ev);
      end
   endtask

   task automatic check_model(input string name);
      logic [3:0] eg;
      eg = m_busy[0] ? (4'b0001 << m_slot[0]) : 4'b0000;
      check({name, "_s4"}, g4, s4, o4, v4, eg, 2'(m_slot[0]), m_out[0], m_valid[0]);
      eg = m_busy[1] ? (4'b0001 << m_slot[1]) : 4'b0000;
      check({name, "_s1"}, g1, s1, o1, v1, eg, 2'(m_slot[1]), m_out[1], m_valid[1]);
   endtask

   // One rising edge; the model follows the same edge; outputs settle 1 ns later.
   task automatic tick();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = 4'b0000;
      tick();
      rst = 1'b1;
   endtask

   task automatic set_in(input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
      in0 = a; in1 = b; in2 = c; in3 = d;
   endtask

   // ---------------- directed vector table (SLOT_LEN=4 instance) ----------------
   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [1:0] d0, d1, d2, d3;
      logic [3:0] g;
      logic [1:0] s;
      logic [1:0] o;
      logic       v;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [3:0] q,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] c, input logic [1:0] d,
                               input logic [3:0] g, input logic [1:0] s,
                               input logic [1:0] o, input logic v);
      vec_t t;
      t.rst_n = r; t.req = q; t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = d;
      t.g = g; t.s = s; t.o = o; t.v = v;
      return t;
   endfunction

   vec_t tbl[21];

   initial begin
      // Reset held for 3 cycles, then full rotation with req=1111.
      tbl[0]  = mk(0, 4'hF, 3, 2, 1, 0, 4'b0000, 0, 0, 0);
      tbl[1]  = mk(0, 4'hF, 3, 2, 1, 0, 4'b0000, 0, 0, 0);
      tbl[2]  = mk(0, 4'hF, 3, 2, 1, 0, 4'b0000, 0, 0, 0);
      tbl[3]  = mk(1, 4'hF, 0, 1, 2, 3, 4'b0001, 0, 0, 0);
      tbl[4]  = mk(1, 4'hF, 0, 1, 2, 3, 4'b0001, 0, 0, 1);
      tbl[5]  = mk(1, 4'hF, 0, 1, 2, 3, 4'b0001, 0, 0, 1);
      tbl[6]  = mk(1, 4'hF, 0, 1, 2, 3, 4'b0001, 0, 0, 1);
      tbl[7]  = mk(1, 4'hF, 0, 1, 2, 3, 4'b0010, 1, 0, 1);
      tbl[8]  = mk(1, 4'hF, 0, 1, 2, 3, 4'b0010, 1, 1, 1);
      tbl[9]  = mk(1, 4'hF, 0, 1, 2, 3, 4'b0010, 1, 1, 1);
      tbl[10] = mk(1, 4'hF, 0, 1, 2, 3, 4'b0010, 1, 1, 1);
      tbl[11] = mk(1, 4'hF, 0, 1, 2, 3, 4'b0100, 2, 1, 1);
      tbl[12] = mk(1, 4'hF, 0, 1, 2, 3, 4'b0100, 2, 2, 1);
      tbl[13] = mk(1, 4'hF, 0, 1, 2, 3, 4'b0100, 2, 2, 1);
      tbl[14] = mk(1, 4'hF, 0, 1, 2, 3, 4'b0100, 2, 2, 1);
      tbl[15] = mk(1, 4'hF, 0, 1, 2, 3, 4'b1000, 3, 2, 1);
      tbl[16] = mk(1, 4'hF, 0, 1, 2, 3, 4'b1000, 3, 3, 1);
      tbl[17] = mk(1, 4'hF, 0, 1, 2, 3, 4'b1000, 3, 3, 1);
      tbl[18] = mk(1, 4'hF, 0, 1, 2, 3, 4'b1000, 3, 3, 1);
      tbl[19] = mk(1, 4'hF, 0, 1, 2, 3, 4'b0001, 0, 3, 1);
      tbl[20] = mk(1, 4'hF, 0, 1, 2, 3, 4'b0001, 0, 0, 1);

      #1 rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         rst = tbl[i].rst_n;
         req = tbl[i].req;
         set_in(tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
         tick();
         check($sformatf("tbl%0d", i), g4, s4, o4, v4,
               tbl[i].g, tbl[i].s, tbl[i].o, tbl[i].v);
      end

      // Single requester: continuous grant across slot boundaries.
      do_reset();
      req = 4'b0010;
      set_in(0, 2, 0, 0);
      tick();
      check("single_e1", g4, s4, o4, v4, 4'b0010, 1, 0, 0);
      for (int e = 2; e <= 10; e++) begin
         tick();
         check($sformatf("single_e%0d", e), g4, s4, o4, v4, 4'b0010, 1, 2, 1);
      end

      // Early release: owner drops during the 2nd cycle of its grant.
      do_reset();
      req = 4'b0011;
      set_in(1, 2, 0, 0);
      tick();
      check("early_e1", g4, s4, o4, v4, 4'b0001, 0, 0, 0);
      tick();
      check("early_e2", g4, s4, o4, v4, 4'b0001, 0, 1, 1);
      req = 4'b0010;
      tick();
      check("early_e3", g4, s4, o4, v4, 4'b0010, 1, 1, 0);
      tick();
      check("early_e4", g4, s4, o4, v4, 4'b0010, 1, 2, 1);

      // Skip/wrap from requester 3 to 1, then drain to IDLE.
      do_reset();
      req = 4'b1000;
      set_in(0, 1, 0, 3);
      tick();
      check("wrap_e1", g4, s4, o4, v4, 4'b1000, 3, 0, 0);
      for (int e = 2; e <= 4; e++) begin
         tick();
         check($sformatf("wrap_e%0d", e), g4, s4, o4, v4, 4'b1000, 3, 3, 1);
      end
      req = 4'b1010;
      tick();
      check("wrap_e5", g4, s4, o4, v4, 4'b0010, 1, 3, 1);
      req = 4'b0000;
      tick();
      check("wrap_e6", g4, s4, o4, v4, 4'b0000, 1, 3, 0);
      tick();
      check("wrap_e7", g4, s4, o4, v4, 4'b0000, 1, 3, 0);

      // Reset mid-operation while grant=0100, count=2.
      do_reset();
      req = 4'b1111;
      set_in(0, 1, 2, 3);
      for (int e = 1; e <= 11; e++) tick();
      check("midrst_before", g4, s4, o4, v4, 4'b0100, 2, 2, 1);
      #2 rst = 1'b0;
      #1;
      check("midrst_async", g4, s4, o4, v4, 4'b0000, 0, 0, 0);
      tick();
      check("midrst_held", g4, s4, o4, v4, 4'b0000, 0, 0, 0);
      rst = 1'b1;
      tick();
      check("midrst_restart", g4, s4, o4, v4, 4'b0001, 0, 0, 0);
      // SLOT_LEN=1 instance restarted on the same edge: pure rotation.
      check("tdm1_e0", g1, s1, o1, v1, 4'b0001, 0, 0, 0);
      for (int e = 1; e <= 4; e++) begin
         tick();
         check($sformatf("tdm1_e%0d", e), g1, s1, o1, v1,
               4'b0001 << (e % 4), 2'(e % 4), 2'(e - 1), 1'b1);
      end

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         set_in(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
         rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         tick();
         check_model($sformatf("rand%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
